id_branch_resolve: RTL and testbench
====================================

// Module: id_branch_resolve
// PURPOSE
//  ID-stage control-flow resolver. Decodes the ID instruction and drives the redirect controls
//  (PCSrc_ID, Branch_Dest_ID, Jump_dst_ID, Jump_control_ID) consumed by the IF next-PC select.
//  Compares forwarded branch operands, and holds PC and IF/ID with a counted stall FSM until
//  in-flight producers are usable. Flushes the wrong-path IF instruction (no delay slot).
//  Keeps saturating taken/stall event counters.
// PARAMETERS
//  CNT_WIDTH  16  width of Taken_Count and Stall_Count
// PORTS
//  clk              in   1   pipeline clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  Valid_ID         in   1   ID holds a real instruction (0 = bubble)
//  Instr_ID         in   32  instruction in ID
//  PC_Plus_4_ID     in   32  address of ID instruction + 4
//  Rs_Data_ID       in   32  forwarded rs operand
//  Rt_Data_ID       in   32  forwarded rt operand
//  EX_RegWrite      in   1   EX instruction writes a register
//  EX_MemRead       in   1   EX instruction is a load
//  EX_Rd            in   5   EX destination register
//  MEM_MemRead      in   1   MEM instruction is a load
//  MEM_Rd           in   5   MEM destination register
//  PCSrc_ID         out  1   take Branch_Dest_ID this cycle
//  Branch_Dest_ID   out  32  PC_Plus_4_ID + (sign_ext(imm16) << 2)
//  Jump_control_ID  out  1   take Jump_dst_ID this cycle (priority over PCSrc_ID)
//  Jump_dst_ID      out  32  J/JAL: {PC_Plus_4_ID[31:28], idx26, 2'b00}; JR: Rs_Data_ID
//  Stall_ID         out  1   hold PC and IF/ID, inject bubble into EX
//  Flush_IF         out  1   load bubble into IF/ID at next edge
//  Taken_Count      out  CNT_WIDTH  redirects taken since reset, saturating
//  Stall_Count      out  CNT_WIDTH  cycles with Stall_ID=1 since reset, saturating
// BEHAVIOUR
//  Decode: BEQ op=6'h04, BNE op=6'h05 (read rs,rt); J op=6'h02, JAL op=6'h03 (no reads);
//   JR op=6'h00 & funct=6'h08 (reads rs). Other encodings: no redirect, no stall. Register 0 never hazards.
//  Hazard need (0..2), reads only: EX_MemRead & EX_Rd match -> 2; else EX_RegWrite & EX_Rd match -> 1;
//   else MEM_MemRead & MEM_Rd match -> 1; else 0.
//  FSM states IDLE, HOLD, RESOLVE; 2-bit counter cnt. Reset: IDLE, cnt=0, both counters 0.
//  IDLE: Valid_ID & need>0 -> Stall_ID=1, no redirect; cnt<=need-1; next = (need==1)?RESOLVE:HOLD.
//        need==0 -> resolve this cycle, stay IDLE.
//  HOLD: Stall_ID=1, cnt<=cnt-1; when cnt==1 -> RESOLVE. Hazard inputs ignored.
//  RESOLVE: Stall_ID=0, resolve with current operands, hazards ignored; -> IDLE.
//  Valid_ID=0 in HOLD/RESOLVE -> IDLE, cnt=0, no outputs asserted.
//  Resolve: BEQ taken iff Rs==Rt, BNE iff Rs!=Rt -> PCSrc_ID=1. J/JAL/JR -> Jump_control_ID=1.
//   Never both asserted. Flush_IF = PCSrc_ID | Jump_control_ID.
//  Redirect/stall outputs combinational from state + inputs; all 0 when Valid_ID=0 or reset asserted.
//   Destination buses always computed (don't-care unless selected).
//  Address arithmetic modulo 2^32; branch target wraps silently.
//  Taken_Count +1 per cycle with Flush_IF=1; Stall_Count +1 per cycle with Stall_ID=1; both hold at all-ones.
//  reset_n low at any time: immediate IDLE, cnt=0, counters 0; ID instruction re-evaluated after release.
// TESTING
//  BEQ rs=rt=5'd3, Rs=Rt=32'h10, no hazards, PC+4=32'h100, imm=16'h0004 -> same cycle PCSrc_ID=1,
//   Branch_Dest_ID=32'h110, Flush_IF=1, Stall_ID=0, Taken_Count 0->1.
//  BNE rs=5'd2 while EX_MemRead=1, EX_Rd=5'd2 -> Stall_ID=1 two cycles, third cycle resolves;
//   Rs!=Rt -> PCSrc_ID=1; Stall_Count=2.
//  JR rs=5'd31, EX_RegWrite=1, EX_Rd=5'd31 -> one stall, next cycle Jump_control_ID=1, Jump_dst_ID=Rs_Data_ID.
//  J idx26=26'h0000040, PC+4=32'h8000_0004 -> Jump_dst_ID=32'h8000_0100, no stall;
//   BEQ with EX_Rd=0 & EX_RegWrite=1 -> no stall.
//  reset_n pulsed low in HOLD -> Stall_ID=0 immediately, counters 0; after release stall re-entered from IDLE.
//  Force Taken_Count to all-ones via 2^CNT_WIDTH taken jumps (CNT_WIDTH=4) -> stays 4'hF on 17th.

Source files
------------

// File: rtl/id_branch_resolve_if.sv
// Signal bundle between the ID-stage branch resolver and the surrounding pipeline:
// ID instruction/operands, EX/MEM hazard sources, redirect controls and event counters.
interface id_branch_resolve_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 Valid_ID;
    logic [31:0]          Instr_ID;
    logic [31:0]          PC_Plus_4_ID;
    logic [31:0]          Rs_Data_ID;
    logic [31:0]          Rt_Data_ID;
    logic                 EX_RegWrite;
    logic                 EX_MemRead;
    logic [4:0]           EX_Rd;
    logic                 MEM_MemRead;
    logic [4:0]           MEM_Rd;
    logic                 PCSrc_ID;
    logic [31:0]          Branch_Dest_ID;
    logic                 Jump_control_ID;
    logic [31:0]          Jump_dst_ID;
    logic                 Stall_ID;
    logic                 Flush_IF;
    logic [CNT_WIDTH-1:0] Taken_Count;
    logic [CNT_WIDTH-1:0] Stall_Count;

    modport master (
        output Valid_ID, Instr_ID, PC_Plus_4_ID, Rs_Data_ID, Rt_Data_ID,
               EX_RegWrite, EX_MemRead, EX_Rd, MEM_MemRead, MEM_Rd,
        input  PCSrc_ID, Branch_Dest_ID, Jump_control_ID, Jump_dst_ID,
               Stall_ID, Flush_IF, Taken_Count, Stall_Count
    );

    modport slave (
        input  Valid_ID, Instr_ID, PC_Plus_4_ID, Rs_Data_ID, Rt_Data_ID,
               EX_RegWrite, EX_MemRead, EX_Rd, MEM_MemRead, MEM_Rd,
        output PCSrc_ID, Branch_Dest_ID, Jump_control_ID, Jump_dst_ID,
               Stall_ID, Flush_IF, Taken_Count, Stall_Count
    );
endinterface

// File: rtl/id_branch_resolve.sv
// ID-stage control-flow resolver: decodes BEQ/BNE/J/JAL/JR, stalls on unresolved
// operand producers with a counted FSM, then redirects fetch and flushes the wrong-path IF slot.
module id_branch_resolve #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    id_branch_resolve_if.slave   br
);
    typedef enum logic [1:0] {IDLE, HOLD, RESOLVE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t       state, state_next;
    logic [1:0]   cnt, cnt_next;
    logic         stall, resolve;

    logic [5:0]   op;
    logic [4:0]   rs, rt;
    logic [15:0]  imm;
    logic [25:0]  idx26;
    logic         is_beq, is_bne, is_j, is_jal, is_jr;
    logic         uses_rs, uses_rt;
    logic         ex_hit, mem_hit;
    logic [1:0]   need;
    logic         operands_eq;
    logic signed [31:0] imm_sext;
    logic         pcsrc, jump, flush;

    // Decode
    assign op     = br.Instr_ID[31:26];
    assign rs     = br.Instr_ID[25:21];
    assign rt     = br.Instr_ID[20:16];
    assign imm    = br.Instr_ID[15:0];
    assign idx26  = br.Instr_ID[25:0];

    assign is_beq = (op == 6'h04);
    assign is_bne = (op == 6'h05);
    assign is_j   = (op == 6'h02);
    assign is_jal = (op == 6'h03);
    assign is_jr  = (op == 6'h00) && (imm[5:0] == 6'h08);

    assign uses_rs = is_beq | is_bne | is_jr;
    assign uses_rt = is_beq | is_bne;

    // Register 0 is hardwired, so a producer targeting it never blocks a read.
    assign ex_hit  = (br.EX_Rd != 5'd0) &&
                     ((uses_rs && (rs == br.EX_Rd)) || (uses_rt && (rt == br.EX_Rd)));
    assign mem_hit = (br.MEM_Rd != 5'd0) &&
                     ((uses_rs && (rs == br.MEM_Rd)) || (uses_rt && (rt == br.MEM_Rd)));

    always_comb begin
        need = 2'd0;
        if (br.EX_MemRead && ex_hit)
            need = 2'd2;
        else if (br.EX_RegWrite && ex_hit)
            need = 2'd1;
        else if (br.MEM_MemRead && mem_hit)
            need = 2'd1;
    end

    // Target computation (always live; only meaningful when selected)
    assign imm_sext          = signed'({{16{imm[15]}}, imm});
    assign br.Branch_Dest_ID = br.PC_Plus_4_ID + $unsigned(imm_sext <<< 2);
    assign br.Jump_dst_ID    = is_jr ? br.Rs_Data_ID : {br.PC_Plus_4_ID[31:28], idx26, 2'b00};
    assign operands_eq       = (br.Rs_Data_ID == br.Rt_Data_ID);

    // Stall FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        resolve    = 1'b0;
        case (state)
            IDLE: begin
                if (br.Valid_ID) begin
                    if (need != 2'd0) begin
                        stall      = 1'b1;
                        cnt_next   = need - 2'd1;
                        state_next = (need == 2'd1) ? RESOLVE : HOLD;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!br.Valid_ID) begin
                    state_next = IDLE;
                    cnt_next   = 2'd0;
                end else begin
                    stall    = 1'b1;
                    cnt_next = cnt - 2'd1;
                    if (cnt <= 2'd1)
                        state_next = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve    = br.Valid_ID;
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // Redirect outputs, forced quiet while reset is held
    assign pcsrc = reset_n && resolve && ((is_beq && operands_eq) || (is_bne && !operands_eq));
    assign jump  = reset_n && resolve && (is_j || is_jal || is_jr);
    assign flush = pcsrc | jump;

    assign br.PCSrc_ID        = pcsrc;
    assign br.Jump_control_ID = jump;
    assign br.Flush_IF        = flush;
    assign br.Stall_ID        = reset_n && stall;

    // Event counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br.Taken_Count <= '0;
            br.Stall_Count <= '0;
        end else begin
            if (flush)
                br.Taken_Count <= sat_inc(br.Taken_Count);
            if (stall)
                br.Stall_Count <= sat_inc(br.Stall_Count);
        end
    end
endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve: hand-computed branch/jump/stall vectors,
// async reset behaviour and saturation of the 4-bit event counters.
module tb_id_branch_resolve;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    id_branch_resolve_if #(.CNT_WIDTH(4)) bus ();

    id_branch_resolve #(.CNT_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .br      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_hazards();
        bus.EX_RegWrite = 1'b0;
        bus.EX_MemRead  = 1'b0;
        bus.EX_Rd       = 5'd0;
        bus.MEM_MemRead = 1'b0;
        bus.MEM_Rd      = 5'd0;
    endtask

    task automatic load_use_bne();
        bus.Valid_ID     = 1'b1;
        bus.Instr_ID     = itype(6'h05, 5'd2, 5'd4, 16'hFFFC);
        bus.PC_Plus_4_ID = 32'h0000_0200;
        bus.Rs_Data_ID   = 32'h1;
        bus.Rt_Data_ID   = 32'h2;
        bus.EX_MemRead   = 1'b1;
        bus.EX_RegWrite  = 1'b1;
        bus.EX_Rd        = 5'd2;
    endtask

    initial begin
        bus.Valid_ID     = 1'b0;
        bus.Instr_ID     = 32'h0;
        bus.PC_Plus_4_ID = 32'h0;
        bus.Rs_Data_ID   = 32'h0;
        bus.Rt_Data_ID   = 32'h0;
        clear_hazards();

        // Reset state, including a valid jump presented during reset
        @(negedge clk);
        bus.Valid_ID = 1'b1;
        bus.Instr_ID = {6'h02, 26'h40};
        #2;
        chk("rst_stall", bus.Stall_ID, 1'b0);
        chk("rst_jump", bus.Jump_control_ID, 1'b0);
        chk("rst_flush", bus.Flush_IF, 1'b0);
        @(negedge clk); #2;
        chk("rst_taken_cnt", bus.Taken_Count, 4'h0);
        chk("rst_stall_cnt", bus.Stall_Count, 4'h0);

        // BEQ taken, no hazards
        @(negedge clk);
        reset_n          = 1'b1;
        bus.Instr_ID     = itype(6'h04, 5'd3, 5'd3, 16'h0004);
        bus.PC_Plus_4_ID = 32'h0000_0100;
        bus.Rs_Data_ID   = 32'h10;
        bus.Rt_Data_ID   = 32'h10;
        #2;
        chk("beq_pcsrc", bus.PCSrc_ID, 1'b1);
        chk("beq_dest", bus.Branch_Dest_ID, 32'h0000_0110);
        chk("beq_flush", bus.Flush_IF, 1'b1);
        chk("beq_stall", bus.Stall_ID, 1'b0);
        chk("beq_jump", bus.Jump_control_ID, 1'b0);
        chk("beq_taken_before", bus.Taken_Count, 4'h0);
        @(negedge clk);
        bus.Valid_ID = 1'b0;
        #2;
        chk("beq_taken_after", bus.Taken_Count, 4'h1);
        chk("bubble_pcsrc", bus.PCSrc_ID, 1'b0);
        chk("bubble_flush", bus.Flush_IF, 1'b0);

        // BNE behind a load in EX: two stall cycles then resolve
        @(negedge clk);
        load_use_bne();
        #2;
        chk("bne_s1_stall", bus.Stall_ID, 1'b1);
        chk("bne_s1_pcsrc", bus.PCSrc_ID, 1'b0);
        @(negedge clk); #2;
        chk("bne_s2_stall", bus.Stall_ID, 1'b1);
        chk("bne_s2_flush", bus.Flush_IF, 1'b0);
        @(negedge clk); #2;
        chk("bne_res_stall", bus.Stall_ID, 1'b0);
        chk("bne_res_pcsrc", bus.PCSrc_ID, 1'b1);
        chk("bne_res_dest", bus.Branch_Dest_ID, 32'h0000_01F0);
        chk("bne_stall_cnt", bus.Stall_Count, 4'h2);
        @(negedge clk);
        bus.Valid_ID = 1'b0;
        clear_hazards();
        #2;
        chk("bne_taken_cnt", bus.Taken_Count, 4'h2);

        // JR behind an ALU producer: one stall then jump to rs
        @(negedge clk);
        bus.Valid_ID    = 1'b1;
        bus.Instr_ID    = {6'h00, 5'd31, 15'd0, 6'h08};
        bus.Rs_Data_ID  = 32'hDEAD_BEE0;
        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd       = 5'd31;
        #2;
        chk("jr_stall", bus.Stall_ID, 1'b1);
        chk("jr_stall_jump", bus.Jump_control_ID, 1'b0);
        @(negedge clk); #2;
        chk("jr_res_stall", bus.Stall_ID, 1'b0);
        chk("jr_res_jump", bus.Jump_control_ID, 1'b1);
        chk("jr_res_pcsrc", bus.PCSrc_ID, 1'b0);
        chk("jr_dst", bus.Jump_dst_ID, 32'hDEAD_BEE0);
        chk("jr_stall_cnt", bus.Stall_Count, 4'h3);

        // J with a load in EX: J reads no registers, so no stall
        @(negedge clk);
        bus.Instr_ID     = {6'h02, 26'h0000040};
        bus.PC_Plus_4_ID = 32'h8000_0004;
        bus.EX_MemRead   = 1'b1;
        bus.EX_Rd        = 5'd5;
        #2;
        chk("j_stall", bus.Stall_ID, 1'b0);
        chk("j_jump", bus.Jump_control_ID, 1'b1);
        chk("j_dst", bus.Jump_dst_ID, 32'h8000_0100);
        chk("j_taken_before", bus.Taken_Count, 4'h3);

        // BEQ on r0 with EX writing r0: no stall, not taken
        @(negedge clk);
        clear_hazards();
        bus.Instr_ID    = itype(6'h04, 5'd0, 5'd0, 16'h0010);
        bus.Rs_Data_ID  = 32'h5;
        bus.Rt_Data_ID  = 32'h6;
        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd       = 5'd0;
        #2;
        chk("beq_r0_stall", bus.Stall_ID, 1'b0);
        chk("beq_r0_pcsrc", bus.PCSrc_ID, 1'b0);
        chk("beq_r0_flush", bus.Flush_IF, 1'b0);
        chk("j_taken_after", bus.Taken_Count, 4'h4);

        // Non-control instruction with a matching load in EX: no stall
        @(negedge clk);
        bus.Instr_ID   = {6'h00, 5'd7, 5'd8, 5'd9, 5'd0, 6'h20};
        bus.EX_MemRead = 1'b1;
        bus.EX_Rd      = 5'd7;
        #2;
        chk("add_stall", bus.Stall_ID, 1'b0);
        chk("add_jump", bus.Jump_control_ID, 1'b0);

        // Bubble during HOLD returns to IDLE; re-entry waits the full two cycles
        @(negedge clk);
        clear_hazards();
        load_use_bne();
        #2;
        chk("drop_s1_stall", bus.Stall_ID, 1'b1);
        @(negedge clk);
        bus.Valid_ID = 1'b0;
        #2;
        chk("drop_bubble_stall", bus.Stall_ID, 1'b0);
        chk("drop_bubble_pcsrc", bus.PCSrc_ID, 1'b0);
        @(negedge clk);
        bus.Valid_ID = 1'b1;
        #2;
        chk("drop_re_s1_stall", bus.Stall_ID, 1'b1);
        @(negedge clk); #2;
        chk("drop_re_s2_stall", bus.Stall_ID, 1'b1);
        @(negedge clk); #2;
        chk("drop_res_stall", bus.Stall_ID, 1'b0);
        chk("drop_res_pcsrc", bus.PCSrc_ID, 1'b1);
        chk("drop_stall_cnt", bus.Stall_Count, 4'h6);
        chk("drop_taken_cnt", bus.Taken_Count, 4'h4);

        // Asynchronous reset while in HOLD
        @(negedge clk);
        load_use_bne();
        #2;
        chk("hold_rst_s1_stall", bus.Stall_ID, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        chk("hold_rst_stall", bus.Stall_ID, 1'b0);
        chk("hold_rst_taken_cnt", bus.Taken_Count, 4'h0);
        chk("hold_rst_stall_cnt", bus.Stall_Count, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("post_rst_s1_stall", bus.Stall_ID, 1'b1);
        @(negedge clk); #2;
        chk("post_rst_s2_stall", bus.Stall_ID, 1'b1);
        @(negedge clk); #2;
        chk("post_rst_res_stall", bus.Stall_ID, 1'b0);
        chk("post_rst_res_pcsrc", bus.PCSrc_ID, 1'b1);
        chk("post_rst_stall_cnt", bus.Stall_Count, 4'h2);

        // Taken_Count saturation over 17 consecutive jumps
        @(negedge clk);
        reset_n = 1'b0;
        clear_hazards();
        #2;
        chk("sat_rst_taken_cnt", bus.Taken_Count, 4'h0);
        @(negedge clk);
        reset_n          = 1'b1;
        bus.Valid_ID     = 1'b1;
        bus.Instr_ID     = {6'h02, 26'h0000040};
        bus.PC_Plus_4_ID = 32'h0000_1004;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk); #2;
            chk("sat_jump", bus.Jump_control_ID, 1'b1);
            chk($sformatf("sat_taken_%0d", k), bus.Taken_Count, (k > 15) ? 32'hF : 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
